// File: rtl/onehot_rx_monitor_pkg.sv
// onehot_pkg
// Shared constants for consumers of the rotating one-hot ring pattern.
// Holds the default ring width, the default lock threshold and the FSM
// state encodings used by onehot_rx_monitor.
// Optional feature macro used elsewhere in this slice: ONEHOT_RX_BIDIR_EN.
package onehot_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int LOCK_CNT_DEF = 4;

  // Encodings are fixed so status software can decode the state directly.
  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/onehot_rx_monitor_if.sv
// onehot_rx_monitor_if
// Bundles the sample strobe/pattern/clear inputs and the status outputs of
// onehot_rx_monitor.
//   master : drives pi_en, pi_a, pi_clr; observes all po_* status.
//   slave  : the monitor itself; reads pi_*, drives po_*.
// With ONEHOT_RX_BIDIR_EN defined an extra po_dir status bit is present.
interface onehot_rx_monitor_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3,
  parameter int ERR_W = 8
);

  logic             pi_en;
  logic [WIDTH-1:0] pi_a;
  logic             pi_clr;
  logic [IDX_W-1:0] po_idx;
  logic             po_idx_vld;
  logic             po_onehot_err;
  logic             po_seq_err;
  logic             po_wrap;
  logic             po_locked;
  logic [ERR_W-1:0] po_err_cnt;
`ifdef ONEHOT_RX_BIDIR_EN
  logic             po_dir;
`endif

  modport master (
    output pi_en, pi_a, pi_clr,
`ifdef ONEHOT_RX_BIDIR_EN
    input  po_dir,
`endif
    input  po_idx, po_idx_vld, po_onehot_err, po_seq_err, po_wrap,
           po_locked, po_err_cnt
  );

  modport slave (
    input  pi_en, pi_a, pi_clr,
`ifdef ONEHOT_RX_BIDIR_EN
    output po_dir,
`endif
    output po_idx, po_idx_vld, po_onehot_err, po_seq_err, po_wrap,
           po_locked, po_err_cnt
  );

endinterface

// File: rtl/onehot_rx_monitor_dec.sv
// onehot_dec
// Purely combinational one-hot decoder, reusable by any ring consumer.
//   a_i     : pattern under test
//   idx_o   : position of the set bit (meaningful only when valid_o=1)
//   valid_o : exactly one bit of a_i is set
module onehot_dec #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // a & (a-1) clears the lowest set bit, so it is zero only for zero or
  // single-bit patterns; the non-zero test removes the all-zero case.
  always_comb begin
    valid_o = (a_i != '0) && ((a_i & (a_i - WIDTH'(1))) == '0);
  end

  // OR of the indices of all set bits; equals the index when one-hot.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a_i[i]) idx_o = idx_o | IDX_W'(i);
    end
  end

endmodule

// File: rtl/onehot_rx_monitor.sv
// onehot_rx_monitor
// Receive-side checker for the rotating one-hot running light. On each
// pi_en strobe the pattern is decoded, checked for one-hot form and for a
// single-position step from the previous sample; a run of LOCK_CNT correct
// steps enters LOCKED. Errors are counted in a saturating counter.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : onehot_rx_monitor_if.slave (pi_en/pi_a/pi_clr in,
//              po_idx/po_idx_vld/po_onehot_err/po_seq_err/po_wrap/
//              po_locked/po_err_cnt out)
// Macro ONEHOT_RX_BIDIR_EN: also accept -1 steps, direction shown on po_dir.
module onehot_rx_monitor
  import onehot_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int IDX_W    = 3,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int ERR_W    = 8
) (
  input logic               clk,
  input logic               rst,
  onehot_rx_monitor_if.slave bus
);

  localparam logic [3:0]       LOCK_V = 4'(LOCK_CNT);
  localparam logic [IDX_W-1:0] TOP_I  = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] decIdx;
  logic             decValid;

  onehot_dec #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec (
    .a_i     (bus.pi_a),
    .idx_o   (decIdx),
    .valid_o (decValid)
  );

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] prev_q, prev_d;
  logic [3:0]       good_q, good_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idxVld_q, idxVld_d;
  logic             ohErr_q, ohErr_d;
  logic             seqErr_q, seqErr_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] fwdIdx;
  logic             stepOk;
  logic             wrapHit;
`ifdef ONEHOT_RX_BIDIR_EN
  logic             dir_q, dir_d;
  logic [IDX_W-1:0] bwdIdx;
`endif

  // Neighbouring positions of the previous sample, with explicit wrap so
  // non-power-of-two widths work too.
  always_comb begin
    fwdIdx = (prev_q == TOP_I) ? '0 : prev_q + IDX_W'(1);
`ifdef ONEHOT_RX_BIDIR_EN
    bwdIdx = (prev_q == '0) ? TOP_I : prev_q - IDX_W'(1);
`endif
  end

  // Step acceptance. With bidirectional support the first step of a run
  // (TRACK, good count 0) may go either way and latches the direction.
  always_comb begin
`ifdef ONEHOT_RX_BIDIR_EN
    dir_d = dir_q;
    if (state_q == ST_TRACK && good_q == 4'd0) begin
      stepOk = (decIdx == fwdIdx) || (decIdx == bwdIdx);
      if (bus.pi_en && decValid && stepOk) dir_d = (decIdx != fwdIdx);
    end else if (dir_q) begin
      stepOk = (decIdx == bwdIdx);
    end else begin
      stepOk = (decIdx == fwdIdx);
    end
    wrapHit = dir_q ? (prev_q == '0) : (prev_q == TOP_I);
`else
    stepOk  = (decIdx == fwdIdx);
    wrapHit = (prev_q == TOP_I);
`endif
  end

  // Main FSM and output next-state. Pulses default low so they only last
  // one cycle; everything else holds unless a strobe arrives.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    good_d   = good_q;
    idx_d    = idx_q;
    idxVld_d = 1'b0;
    ohErr_d  = 1'b0;
    seqErr_d = 1'b0;
    wrap_d   = 1'b0;
    if (bus.pi_en) begin
      if (decValid) begin
        idx_d    = decIdx;
        idxVld_d = 1'b1;
      end
      case (state_q)
        ST_HUNT: begin
          if (decValid) begin
            state_d = ST_TRACK;
            prev_d  = decIdx;
            good_d  = 4'd0;
          end else begin
            ohErr_d = 1'b1;
          end
        end
        ST_TRACK, ST_LOCKED: begin
          if (!decValid) begin
            ohErr_d = 1'b1;
            state_d = ST_HUNT;
            good_d  = 4'd0;
          end else if (stepOk) begin
            prev_d = decIdx;
            if (state_q == ST_LOCKED) begin
              wrap_d = wrapHit;
            end else begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_V) state_d = ST_LOCKED;
            end
          end else begin
            seqErr_d = 1'b1;
            state_d  = ST_TRACK;
            good_d   = 4'd0;
            prev_d   = decIdx;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Error counter: clear wins over a same-cycle increment; saturates.
  always_comb begin
    err_d = err_q;
    if (bus.pi_clr) begin
      err_d = '0;
    end else if ((ohErr_d || seqErr_d) && err_q != '1) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      prev_q   <= '0;
      good_q   <= 4'd0;
      idx_q    <= '0;
      idxVld_q <= 1'b0;
      ohErr_q  <= 1'b0;
      seqErr_q <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= '0;
`ifdef ONEHOT_RX_BIDIR_EN
      dir_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      good_q   <= good_d;
      idx_q    <= idx_d;
      idxVld_q <= idxVld_d;
      ohErr_q  <= ohErr_d;
      seqErr_q <= seqErr_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
`ifdef ONEHOT_RX_BIDIR_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign bus.po_idx        = idx_q;
  assign bus.po_idx_vld    = idxVld_q;
  assign bus.po_onehot_err = ohErr_q;
  assign bus.po_seq_err    = seqErr_q;
  assign bus.po_wrap       = wrap_q;
  assign bus.po_locked     = (state_q == ST_LOCKED);
  assign bus.po_err_cnt    = err_q;
`ifdef ONEHOT_RX_BIDIR_EN
  assign bus.po_dir        = dir_q;
`endif

endmodule

// File: doc/onehot_rx_monitor.md
Name: onehot_rx_monitor

Overview:
- Receive-side checker for the 8-bit rotating one-hot ring pattern, i.e. the {a[6:0],a[7]} left-rotate running light.
- Samples the pattern on a strobe, decodes it to a bit index and validates one-hot form.
- Checks that each sample is the previous one rotated by one position, declares lock after a run of correct steps, and counts errors.
- Sits downstream of the ring generator, for self-check and status LEDs.

Parameters:
- WIDTH, 8: ring width in bits.
- IDX_W, 3: index width; must equal clog2(WIDTH).
- LOCK_CNT, 4: consecutive correct steps needed to enter LOCKED; range 1..15.
- ERR_W, 8: error counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pi_en  in  1  sample strobe, one pulse per ring step.
- pi_a  in  WIDTH  ring pattern under test.
- pi_clr  in  1  clears po_err_cnt.
- po_idx  out  IDX_W  index of the set bit in the last valid sample.
- po_idx_vld  out  1  1-cycle pulse: a valid one-hot sample was decoded.
- po_onehot_err  out  1  1-cycle pulse: sample had zero bits set, or two or more bits set.
- po_seq_err  out  1  1-cycle pulse: valid one-hot sample but wrong step.
- po_wrap  out  1  1-cycle pulse: correct step from WIDTH-1 to 0 while LOCKED.
- po_locked  out  1  level, high in LOCKED.
- po_err_cnt  out  ERR_W  saturating error count.

Behaviour:
- Reset:
  - rst has highest priority and is synchronous.
  - Effect: state=HUNT, po_idx=0, all pulses=0, po_locked=0, po_err_cnt=0, good_cnt=0.
  - Reset mid-operation discards lock and history.
- Latency:
  - All outputs are registered.
  - A sample taken with pi_en=1 in cycle N is reflected on the outputs in cycle N+1.
- When pi_en=0:
  - No state change.
  - Pulses are 0.
  - po_idx and po_locked hold.
- Decode:
  - valid = exactly one bit set.
  - idx = position of that bit.
  - expected = (prev_idx+1) mod WIDTH; wrap is explicit at WIDTH-1→0.
- FSM states: HUNT, TRACK, LOCKED.
  - HUNT:
    - Valid sample → TRACK, prev=idx, good_cnt=0.
    - Invalid sample → onehot_err, stay in HUNT.
    - No seq_err is possible in HUNT.
  - TRACK:
    - Valid and idx==expected → good_cnt+1. When good_cnt reaches LOCK_CNT → LOCKED.
    - Valid and wrong step → seq_err, good_cnt=0, prev=idx, stay in TRACK.
    - Invalid sample → onehot_err, go to HUNT.
  - LOCKED:
    - Correct step → stay in LOCKED; po_wrap=1 if prev==WIDTH-1.
    - Wrong step → seq_err, go to TRACK, good_cnt=0, prev=idx.
    - Invalid sample → onehot_err, go to HUNT.
- Repeated identical sample (no rotation) is a seq_err.
- po_idx and po_idx_vld update on every valid sample, in any state.
- po_err_cnt:
  - Increments by 1 on each onehot_err or seq_err.
  - Saturates at all-ones.
  - pi_clr forces 0 and beats a same-cycle increment; rst beats pi_clr.

Optional Feature:
- Macro: ONEHOT_RX_BIDIR_EN.
- Without it: only +1 (left-rotate) steps are correct; behaviour exactly as above.
- With it:
  - Adds output po_dir, 1 bit: 0 = +1 direction, 1 = -1 direction; reset 0.
  - In TRACK with good_cnt==0, either +1 or -1 is accepted and latches po_dir.
  - After that, only the latched direction is correct.
  - Entering HUNT, or a seq_err, unlatches the direction.
  - po_wrap also fires on a correct 0→WIDTH-1 step when po_dir=1.

Decomposition:
- Package onehot_pkg holds:
  - WIDTH default of 8.
  - State encodings: ST_HUNT=2'd0, ST_TRACK=2'd1, ST_LOCKED=2'd2.
  - LOCK_CNT default.
- Sub-module onehot_dec:
  - Purely combinational, WIDTH→{idx, valid}.
  - Reusable by other ring consumers.
- The top level holds the FSM, counters and output registers.

Test Plan:
- Reset, then pi_en pulses with pi_a=01,02,04,08,10 → po_idx 0,1,2,3,4 with po_idx_vld each step; po_locked=1 the cycle after the 10 sample (LOCK_CNT=4); po_err_cnt=0.
- Locked at 40, then 80, then 01 → po_wrap=1 one cycle after the 01 sample; po_locked stays 1.
- Locked at 04, then 00 → po_onehot_err=1, po_locked=0, state HUNT, po_err_cnt=1. Repeat with 0x18 → po_err_cnt=2.
- Locked at 04, then 04 again → po_seq_err=1, po_locked=0. Then 08,10,20,40 → relock.
- Force po_err_cnt to 255 via 300 bad samples → holds at 255. pi_clr and a bad sample in the same cycle → 0.
- rst asserted while locked, in the same cycle as pi_en=1 → next cycle all outputs at reset values; sample ignored.
- With ONEHOT_RX_BIDIR_EN defined: 80,40,20,10,08 → po_locked=1 and po_dir=1.
